medium_buffer_reader: RTL and testbench
=======================================

MEDIUM_BUFFER_READER -- requirements
Module: medium_buffer_reader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port wr_strobe, input, 1; writer committed one byte to the shared 4-entry buffer this cycle.
REQ-004 SHALL have port rd_addr, output, 2; read address into the shared buffer, equal to internal rd_ptr.
REQ-005 SHALL have port rd_data, input, 8; combinational buffer contents at rd_addr.
REQ-006 SHALL have port out_valid, output, 1; out_data holds an unread byte.
REQ-007 SHALL have port out_ready, input, 1; consumer accepts when out_valid and out_ready are both high at a rising edge.
REQ-008 SHALL have port out_data, output, 8; byte presented to the consumer.
REQ-009 SHALL have port out_match, output, 1; out_data is one of {0,10,20,30,40}, qualified by out_valid.
REQ-010 SHALL have port level, output, 3; number of unread entries, range 0..4.
REQ-011 SHALL have port ovf, output, 1; sticky overflow flag.
REQ-012 SHALL have port clr_ovf, input, 1; synchronous clear of ovf.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, PRESENT.
REQ-014 IDLE: out_valid=0; transition to FETCH when level>0.
REQ-015 FETCH (one cycle): on exit, capture rd_data into out_data, compute out_match from the captured byte, go to PRESENT.
REQ-016 PRESENT: out_valid=1; out_data and out_match SHALL hold stable until accepted.
REQ-017 On accept: rd_ptr increments mod 4 (3->0 wrap), level decrements; next state SHALL be FETCH if the post-update level>0, else IDLE.
REQ-018 Latency: wr_strobe at edge N with level 0 in IDLE SHALL give out_valid=1 after edge N+2.
REQ-019 Accept with out_ready held high SHALL sustain one byte per 2 cycles (PRESENT/FETCH alternate).
REQ-020 level update: +1 on wr_strobe, -1 on accept; both in the same cycle leave level unchanged.
REQ-021 wr_strobe with level=4 and no accept in the same cycle SHALL set ovf=1 and hold level at 4; rd_ptr is unchanged.
REQ-022 wr_strobe with level=4 and a simultaneous accept SHALL NOT set ovf.
REQ-023 clr_ovf SHALL clear ovf; a same-cycle overflow event takes priority and ovf stays 1.
REQ-024 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-025 rst low SHALL immediately force state=IDLE, rd_ptr=0, level=0, out_valid=0, out_data=0x00, out_match=0, ovf=0.
REQ-026 Reset asserted mid-PRESENT SHALL drop out_valid without waiting for acceptance; a pending byte is discarded.
REQ-027 The first rising edge after rst deasserts SHALL sample wr_strobe normally.

Configuration
REQ-028 Macro MEDIUM_READER_MATCH_EN defined: out_match SHALL behave per REQ-009/REQ-015.
REQ-029 MEDIUM_READER_MATCH_EN undefined: out_match SHALL be constant 0, with no compare logic; all other behaviour is identical.

Verification
REQ-030 Reset, one wr_strobe with rd_data=0x0A, out_ready=1 -> out_valid high at edge 2 after the strobe, out_data=0x0A, out_match=1 (macro on), level returns to 0.
REQ-031 Four strobes with bytes 0x01..0x04 and out_ready=0 -> level=4, ovf=0; then out_ready=1 -> bytes 0x01,0x02,0x03,0x04 in order, rd_addr wraps 3->0.
REQ-032 Level=4, fifth wr_strobe with no accept -> ovf=1, level=4; pulse clr_ovf -> ovf=0; clr_ovf coincident with an overflow -> ovf stays 1.
REQ-033 Level=4, wr_strobe coincident with accept -> level stays 4, ovf=0.
REQ-034 rst pulled low while out_valid=1 with level=3 -> out_valid=0, level=0, rd_addr=0 with no clock edge.
REQ-035 Byte 0x15 presented -> out_match=0; macro undefined, byte 0x14 -> out_match=0.

Source files
------------

// File: rtl/medium_buffer_reader.sv
// ---------------------------------------------------------------------------
// medium_buffer_reader
//
// Read side of a shared 4-entry byte buffer. The writer pulses wr_strobe each
// time it commits a byte; this block tracks how many entries are unread. It
// fetches each byte through rd_addr/rd_data and presents it to a
// valid/ready consumer.
//
// Each byte goes through three states. IDLE waits for data. FETCH spends one
// cycle and captures rd_data on exit. PRESENT holds the byte until the
// consumer accepts it.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-low reset
//   wr_strobe  in   writer committed one byte this cycle
//   rd_addr    out  [1:0] read address into the shared buffer (= rd_ptr)
//   rd_data    in   [7:0] combinational buffer contents at rd_addr
//   out_valid  out  out_data holds an unread byte
//   out_ready  in   consumer accepts when out_valid & out_ready at an edge
//   out_data   out  [7:0] byte presented to the consumer
//   out_match  out  out_data is one of {0,10,20,30,40} (qualify with out_valid)
//   level      out  [2:0] number of unread entries, 0..4
//   ovf        out  sticky overflow flag (write while full, no accept)
//   clr_ovf    in   synchronous clear of ovf (an overflow in the same cycle wins)
//
// Configuration
//   MEDIUM_READER_MATCH_EN  defined: out_match is computed from the captured
//                           byte. Undefined: out_match is tied to 0 and no
//                           compare logic is built.
// ---------------------------------------------------------------------------
module medium_buffer_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_strobe,
  output logic [1:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_match,
  output logic [2:0] level,
  output logic       ovf,
  input  logic       clr_ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [2:0] DEPTH = 3'd4;

  state_t     state;
  state_t     state_next;
  logic [1:0] rd_ptr;
  logic [2:0] level_next;
  logic       accept;
  logic       full;
  logic       ovf_event;

  assign rd_addr   = rd_ptr;
  // out_valid is decoded from the state, so an asynchronous reset drops it
  // immediately and discards any byte being presented.
  assign out_valid = (state == PRESENT);
  assign accept    = out_valid && out_ready;
  assign full      = (level == DEPTH);
  // A write into a full buffer is only an overflow if no slot frees up in the
  // same cycle.
  assign ovf_event = wr_strobe && full && !accept;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_next = level;
    if (wr_strobe && !accept && !full) begin
      level_next = level + 3'd1;
    end else if (accept && !wr_strobe) begin
      level_next = level - 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (level != 3'd0) state_next = FETCH;
      FETCH:   state_next = PRESENT;
      PRESENT: if (accept) state_next = (level_next != 3'd0) ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rd_ptr   <= 2'd0;
      level    <= 3'd0;
      ovf      <= 1'b0;
      out_data <= 8'h00;
    end else begin
      state <= state_next;
      level <= level_next;
      if (accept) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (ovf_event) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
      if (state == FETCH) begin
        out_data <= rd_data;
      end
    end
  end

`ifdef MEDIUM_READER_MATCH_EN
  logic match_cmp;

  assign match_cmp = rd_data inside {8'd0, 8'd10, 8'd20, 8'd30, 8'd40};

  // The match flag is registered alongside out_data, so both stay stable
  // while the byte is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_match <= 1'b0;
    end else if (state == FETCH) begin
      out_match <= match_cmp;
    end
  end
`else
  assign out_match = 1'b0;
`endif

endmodule

// File: tb/tb_medium_buffer_reader.sv
// ---------------------------------------------------------------------------
// tb_medium_buffer_reader
//
// Self-checking bench for medium_buffer_reader. The bench models the shared
// 4-entry buffer and the writer. Each byte the writer commits is pushed to a
// scoreboard queue, and the byte is popped and compared when the consumer
// accepts. A small reference model covers level, ovf and rd_addr.
//
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge too, which is away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_medium_buffer_reader;

  logic       clk;
  logic       rst;
  logic       wr_strobe;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_match;
  logic [2:0] level;
  logic       ovf;
  logic       clr_ovf;

  medium_buffer_reader dut (
    .clk       (clk),
    .rst       (rst),
    .wr_strobe (wr_strobe),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_match (out_match),
    .level     (level),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared buffer owned by the writer side.
  logic [7:0] mem [4];
  assign rd_data = mem[rd_addr];

  // Scoreboard and reference model.
  logic [7:0] sb [$];
  logic [1:0] w_ptr;
  logic [1:0] m_rptr;
  logic [2:0] m_level;
  logic       m_ovf;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic match_of(input logic [7:0] b);
`ifdef MEDIUM_READER_MATCH_EN
    return b inside {8'd0, 8'd10, 8'd20, 8'd30, 8'd40};
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle. The caller is at a falling edge. The task drives the
  // inputs, scores any accept, updates the model, advances to the next
  // falling edge and checks the state registers.
  task automatic step(input logic wr, input logic [7:0] b, input logic rdy, input logic clr);
    logic       acc;
    logic       full;
    logic [7:0] exp;
    wr_strobe = wr;
    out_ready = rdy;
    clr_ovf   = clr;
    acc  = out_valid && rdy;
    full = (m_level == 3'd4);
    if (acc) begin
      if (sb.size() == 0) begin
        check("unexpected_accept", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        check("out_data", 32'(out_data), 32'(exp));
        check("out_match", 32'(out_match), 32'(match_of(exp)));
      end
    end
    if (wr && full && !acc) begin
      m_ovf = 1'b1;
    end else begin
      if (clr) m_ovf = 1'b0;
      if (wr) begin
        mem[w_ptr] = b;
        w_ptr      = w_ptr + 2'd1;
        sb.push_back(b);
      end
    end
    if (wr && !acc && !full) m_level = m_level + 3'd1;
    else if (acc && !wr)     m_level = m_level - 3'd1;
    if (acc) m_rptr = m_rptr + 2'd1;
    @(posedge clk);
    @(negedge clk);
    check("level", 32'(level), 32'(m_level));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("rd_addr", 32'(rd_addr), 32'(m_rptr));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 10) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    check("wait_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    w_ptr   = 2'd0;
    m_rptr  = 2'd0;
    m_level = 3'd0;
    m_ovf   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    rst       = 1'b0;
    wr_strobe = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();

    // Reset values, before any clock edge.
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_match", 32'(out_match), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single byte 0x0A: out_valid rises after the second edge following the strobe.
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    check("lat_n", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_n1", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_n2", 32'(out_valid), 32'd1);
    drain();

    // out_ready while idle is ignored.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Four bytes with the consumer stalled, then drained in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    wait_valid();
    drain();

    // Overflow, clear, and clear colliding with an overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    wait_valid();
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h56, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Full buffer: a write coinciding with an accept keeps the level at 4 and does not set ovf.
    step(1'b1, 8'h66, 1'b1, 1'b0);
    drain();

    // out_match across matching and non-matching bytes.
    step(1'b1, 8'h15, 1'b0, 1'b0);
    step(1'b1, 8'h14, 1'b0, 1'b0);
    step(1'b1, 8'h28, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    drain();

    // Reset while presenting with three entries unread.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    wait_valid();
    check("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst       = 1'b0;
    wr_strobe = 1'b0;
    out_ready = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_addr", 32'(rd_addr), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // The first edge after reset release samples wr_strobe.
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
